// File: rtl/ring_cnt_pkg.sv
// Shared definitions for the ring/Johnson phase counter: mode encodings and
// the start pattern that the correction path loads.
package ring_cnt_pkg;

  localparam logic MODE_RING = 1'b0;
  localparam logic MODE_JOHN = 1'b1;

  // Widest counter the start-pattern helper can describe.
  localparam int MAX_N = 64;

  // Start pattern for a mode: ring restarts at 0...01, Johnson at all-zero.
  // Callers cast the result down to their own width.
  function automatic logic [MAX_N-1:0] ring_start(input logic mode, input int n);
    ring_start = '0;
    if (mode == MODE_RING && n >= 1) begin
      ring_start[0] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ring_cnt_chk.sv
// Legality and position decoder for the counter state. Purely combinational;
// shared by the next-state, terminal-count and idx paths of the top level.
module ring_cnt_chk
  import ring_cnt_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(2*N)
) (
  input  logic [N-1:0]  q,
  input  logic          mode,
  output logic          legal,
  output logic [IW-1:0] idx
);

  logic          ring_legal;
  logic [IW-1:0] ring_idx;
  logic          john_legal;
  logic [IW-1:0] john_idx;
  logic [N-1:0]  lo_pat;
  logic [N-1:0]  hi_pat;

  // One-hot ring: legal when exactly one bit is set, idx is that bit's position.
  always_comb begin
    ring_legal = $onehot(q);
    ring_idx   = '0;
    for (int b = 0; b < N; b++) begin
      if (q[b]) ring_idx = IW'(b);
    end
  end

  // Johnson: compare against every legal pattern. k low ones is up-step k;
  // k high ones (0 < k < N) is up-step 2N-k, i.e. the falling half of the cycle.
  always_comb begin
    john_legal = 1'b0;
    john_idx   = '0;
    lo_pat     = '0;
    hi_pat     = '0;
    for (int k = 0; k <= N; k++) begin
      for (int b = 0; b < N; b++) begin
        lo_pat[b] = (b < k);
        hi_pat[b] = (b >= N - k);
      end
      if (q == lo_pat) begin
        john_legal = 1'b1;
        john_idx   = IW'(k);
      end
      if (k > 0 && k < N && q == hi_pat) begin
        john_legal = 1'b1;
        john_idx   = IW'(2*N - k);
      end
    end
  end

  // Select by mode; an illegal state always reports position 0.
  always_comb begin
    legal = (mode == MODE_JOHN) ? john_legal : ring_legal;
    idx   = '0;
    if (legal) idx = (mode == MODE_JOHN) ? john_idx : ring_idx;
  end

endmodule

// File: rtl/ring_cnt_p.sv
// N-bit shift-type phase counter, run-time selectable between one-hot ring
// and Johnson sequencing, with load, direction, enable, illegal-state
// self-correction, position index and terminal-count flag.
module ring_cnt_p
  import ring_cnt_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(2*N)
) (
  input  logic          ck,
  input  logic          res,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          ld,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic [IW-1:0] idx,
  output logic          tc,
  output logic          err
);

  localparam logic [N-1:0] RESET_Q = N'(1);

  logic         legal;
  logic         wrap;
  logic [N-1:0] start_pat;
  logic [N-1:0] step_q;
  logic         feed_up;
  logic         feed_dn;

  ring_cnt_chk #(.N(N), .IW(IW)) u_chk (
    .q     (q),
    .mode  (mode),
    .legal (legal),
    .idx   (idx)
  );

  assign start_pat = N'(ring_start(mode, N));

  // One enabled step; the wrapped-in bit is inverted in Johnson mode (mode=1).
  always_comb begin
    feed_up = q[N-1] ^ mode;
    feed_dn = q[0] ^ mode;
    step_q  = dir ? {q[N-2:0], feed_up} : {feed_dn, q[N-1:1]};
  end

  // Terminal count: the next enabled step from a legal state wraps the cycle.
  always_comb begin
    wrap = 1'b0;
    if (mode == MODE_JOHN) wrap = dir ? (idx == IW'(2*N - 1)) : (idx == '0);
    else                   wrap = dir ? q[N-1] : q[0];
    tc = en & ~ld & legal & wrap;
  end

  // State update, priority load > correction > step > hold.
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      q   <= RESET_Q;
      err <= 1'b0;
    end else if (ld) begin
      q   <= d;
      err <= 1'b0;
    end else if (!legal) begin
      q   <= start_pat;
      err <= 1'b1;
    end else begin
      err <= 1'b0;
      if (en) q <= step_q;
    end
  end

endmodule

// File: tb/tb_ring_cnt_p.sv
// Self-checking bench for ring_cnt_p: N=4 instance for ring/Johnson/load/
// correction/hold/reset scenarios, N=6 instance for a full Johnson cycle.
module tb_ring_cnt_p;

  logic       ck = 1'b0;
  logic       res = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       mode = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] d4 = '0;
  logic [5:0] d6 = '0;

  logic [3:0] q4;
  logic [2:0] idx4;
  logic       tc4, err4;
  logic [5:0] q6;
  logic [3:0] idx6;
  logic       tc6, err6;

  ring_cnt_p #(.N(4)) dut4 (
    .ck(ck), .res(res), .en(en), .dir(dir), .mode(mode), .ld(ld), .d(d4),
    .q(q4), .idx(idx4), .tc(tc4), .err(err4)
  );

  ring_cnt_p #(.N(6)) dut6 (
    .ck(ck), .res(res), .en(en), .dir(dir), .mode(mode), .ld(ld), .d(d6),
    .q(q6), .idx(idx6), .tc(tc6), .err(err6)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [5:0] q;
    logic [3:0] idx;
    logic       tc;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input logic [5:0] q, input logic [3:0] idx,
                      input logic tc, input logic err, input string tag);
    exp_t e;
    e.q = q; e.idx = idx; e.tc = tc; e.err = err; e.tag = tag;
    sb.push_back(e);
  endtask

  // Reference Johnson pattern at up-step k of an n-bit counter.
  function automatic logic [5:0] john_pat(input int k, input int n);
    logic [5:0] p;
    p = '0;
    for (int b = 0; b < n; b++) p[b] = (k <= n) ? (b < k) : (b >= k - n);
    return p;
  endfunction

  // Asynchronous reset pulse applied mid-cycle, released on a falling edge.
  task automatic pulse_reset();
    @(posedge ck); #1;
    en = 1'b0; ld = 1'b0;
    res = 1'b0;
    #2;
    @(negedge ck);
    res = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    mode = 1'b0; dir = 1'b1;
    @(posedge ck); #1;
    en = 1'b0; ld = 1'b0; res = 1'b0;
    #2;
    push(6'h1, 4'd0, 1'b0, 1'b0, "reset");
    e = sb.pop_front(); checks++;
    if (q4 !== e.q[3:0] || idx4 !== e.idx[2:0] || tc4 !== e.tc || err4 !== e.err) begin
      errors++;
      $display("FAIL %s: got q=%h idx=%0d tc=%b err=%b, want q=%h idx=%0d tc=%b err=%b",
               e.tag, q4, idx4, tc4, err4, e.q[3:0], e.idx, e.tc, e.err);
    end else $display("ok %s: q=%h idx=%0d tc=%b err=%b", e.tag, q4, idx4, tc4, err4);
    @(negedge ck);
    res = 1'b1;
  endtask

  task automatic test_ring_up();
    logic [3:0] qt [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [2:0] it [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic       tt [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    pulse_reset();
    mode = 1'b0; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push({2'b0, qt[i]}, {1'b0, it[i]}, tt[i], 1'b0, $sformatf("ring_up[%0d]", i));
      if (i > 0) @(posedge ck);
      #1;
      e = sb.pop_front(); checks++;
      if (q4 !== e.q[3:0] || idx4 !== e.idx[2:0] || tc4 !== e.tc || err4 !== e.err) begin
        errors++;
        $display("FAIL %s: got q=%h idx=%0d tc=%b err=%b, want q=%h idx=%0d tc=%b err=%b",
                 e.tag, q4, idx4, tc4, err4, e.q[3:0], e.idx, e.tc, e.err);
      end else $display("ok %s: q=%h idx=%0d tc=%b err=%b", e.tag, q4, idx4, tc4, err4);
    end
  endtask

  task automatic test_ring_down();
    logic [3:0] qt [5] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h1};
    logic [2:0] it [5] = '{3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
    logic       tt [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;
    dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push({2'b0, qt[i]}, {1'b0, it[i]}, tt[i], 1'b0, $sformatf("ring_down[%0d]", i));
      if (i > 0) @(posedge ck);
      #1;
      e = sb.pop_front(); checks++;
      if (q4 !== e.q[3:0] || idx4 !== e.idx[2:0] || tc4 !== e.tc || err4 !== e.err) begin
        errors++;
        $display("FAIL %s: got q=%h idx=%0d tc=%b err=%b, want q=%h idx=%0d tc=%b err=%b",
                 e.tag, q4, idx4, tc4, err4, e.q[3:0], e.idx, e.tc, e.err);
      end else $display("ok %s: q=%h idx=%0d tc=%b err=%b", e.tag, q4, idx4, tc4, err4);
    end
  endtask

  task automatic test_johnson();
    // Up through a full cycle and part of the next, then reverse at q=C.
    logic [3:0] qt [16] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0,
                            4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'hC, 4'hE};
    logic [2:0] it [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
                            3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd5};
    exp_t e;
    pulse_reset();
    mode = 1'b1; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push({2'b0, qt[i]}, {1'b0, it[i]}, (i == 6), 1'b0, $sformatf("johnson[%0d]", i));
      if (i == 14) dir = 1'b0;
      else if (i > 0) @(posedge ck);
      #1;
      e = sb.pop_front(); checks++;
      if (q4 !== e.q[3:0] || idx4 !== e.idx[2:0] || tc4 !== e.tc || err4 !== e.err) begin
        errors++;
        $display("FAIL %s: got q=%h idx=%0d tc=%b err=%b, want q=%h idx=%0d tc=%b err=%b",
                 e.tag, q4, idx4, tc4, err4, e.q[3:0], e.idx, e.tc, e.err);
      end else $display("ok %s: q=%h idx=%0d tc=%b err=%b", e.tag, q4, idx4, tc4, err4);
    end
  endtask

  task automatic test_load_correct();
    // Load an illegal ring value, then expect one correction cycle with err.
    logic [3:0] qt [5] = '{4'hE, 4'h5, 4'h1, 4'h2, 4'h4};
    logic [2:0] it [5] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
    logic       et [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t e;
    mode = 1'b0; dir = 1'b1; en = 1'b1; ld = 1'b1; d4 = 4'h5;
    for (int i = 0; i < 5; i++) begin
      push({2'b0, qt[i]}, {1'b0, it[i]}, 1'b0, et[i], $sformatf("load_correct[%0d]", i));
      if (i > 0) @(posedge ck);
      #1;
      e = sb.pop_front(); checks++;
      if (q4 !== e.q[3:0] || idx4 !== e.idx[2:0] || tc4 !== e.tc || err4 !== e.err) begin
        errors++;
        $display("FAIL %s: got q=%h idx=%0d tc=%b err=%b, want q=%h idx=%0d tc=%b err=%b",
                 e.tag, q4, idx4, tc4, err4, e.q[3:0], e.idx, e.tc, e.err);
      end else $display("ok %s: q=%h idx=%0d tc=%b err=%b", e.tag, q4, idx4, tc4, err4);
      if (i == 1) ld = 1'b0;
    end
  endtask

  task automatic test_hold_load();
    exp_t e;
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) push(6'h4, 4'd2, 1'b0, 1'b0, $sformatf("hold[%0d]", i));
      else if (i == 5) push(6'h2, 4'd1, 1'b0, 1'b0, "load_over_step");
      else push(6'h4, 4'd2, 1'b0, 1'b0, "step_after_load");
      if (i == 5) begin ld = 1'b1; d4 = 4'h2; en = 1'b1; end
      @(posedge ck); #1;
      e = sb.pop_front(); checks++;
      if (q4 !== e.q[3:0] || idx4 !== e.idx[2:0] || tc4 !== e.tc || err4 !== e.err) begin
        errors++;
        $display("FAIL %s: got q=%h idx=%0d tc=%b err=%b, want q=%h idx=%0d tc=%b err=%b",
                 e.tag, q4, idx4, tc4, err4, e.q[3:0], e.idx, e.tc, e.err);
      end else $display("ok %s: q=%h idx=%0d tc=%b err=%b", e.tag, q4, idx4, tc4, err4);
      if (i == 5) ld = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    // Steps marked r are observed after an async reset between edges.
    logic [3:0] qt [7] = '{4'h8, 4'h1, 4'h2, 4'h3, 4'h1, 4'h1, 4'h2};
    logic [2:0] it [7] = '{3'd3, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};
    logic       tt [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       et [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       rt [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    en = 1'b1; dir = 1'b1; mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push({2'b0, qt[i]}, {1'b0, it[i]}, tt[i], et[i], $sformatf("async_reset[%0d]", i));
      if (rt[i]) begin
        #2; res = 1'b0; #1;
      end else begin
        @(posedge ck); #1;
      end
      e = sb.pop_front(); checks++;
      if (q4 !== e.q[3:0] || idx4 !== e.idx[2:0] || tc4 !== e.tc || err4 !== e.err) begin
        errors++;
        $display("FAIL %s: got q=%h idx=%0d tc=%b err=%b, want q=%h idx=%0d tc=%b err=%b",
                 e.tag, q4, idx4, tc4, err4, e.q[3:0], e.idx, e.tc, e.err);
      end else $display("ok %s: q=%h idx=%0d tc=%b err=%b", e.tag, q4, idx4, tc4, err4);
      if (rt[i]) begin
        @(negedge ck); res = 1'b1;
      end
      if (i == 2) begin ld = 1'b1; d4 = 4'h3; end
      if (i == 3) ld = 1'b0;
    end
  endtask

  task automatic test_johnson6();
    exp_t e;
    int   k;
    int   tc_seen;
    tc_seen = 0;
    pulse_reset();
    mode = 1'b1; dir = 1'b1; en = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      k = (1 + i) % 12;
      push(john_pat(k, 6), 4'(k), (k == 11), 1'b0, $sformatf("johnson6[%0d]", i));
      if (i > 0) @(posedge ck);
      #1;
      e = sb.pop_front(); checks++;
      if (q6 !== e.q || idx6 !== e.idx || tc6 !== e.tc || err6 !== e.err) begin
        errors++;
        $display("FAIL %s: got q=%h idx=%0d tc=%b err=%b, want q=%h idx=%0d tc=%b err=%b",
                 e.tag, q6, idx6, tc6, err6, e.q, e.idx, e.tc, e.err);
      end else $display("ok %s: q=%h idx=%0d tc=%b err=%b", e.tag, q6, idx6, tc6, err6);
      if (i > 0 && tc6 === 1'b1) tc_seen++;
    end
    checks++;
    if (tc_seen !== 1) begin
      errors++;
      $display("FAIL johnson6_tc_count: got %0d tc pulses, want 1", tc_seen);
    end else $display("ok johnson6_tc_count: %0d tc pulse per cycle", tc_seen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ring_up();
    test_ring_down();
    test_johnson();
    test_load_correct();
    test_hold_load();
    test_async_reset();
    test_johnson6();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
